muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operands/op presented.
REQ-005 SHALL have port in_ready, output, 1, unit can accept; high only in IDLE.
REQ-006 SHALL have ports a and b, input, XLEN, rs1 and rs2 operands.
REQ-007 SHALL have port op, input, 3, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port flush, input, 1, abort any operation in flight.
REQ-009 SHALL have ports out_valid (output, 1, result available) and out_ready (input, 1, consumer takes result).
REQ-010 SHALL have ports result (output, XLEN, result), zero (output, 1, result==0) and illegal (output, 1, op not implemented).

Function
REQ-011 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; transfer in when in_valid&&in_ready, out when out_valid&&out_ready.
REQ-012 SHALL latch a, b and op on input transfer; inputs ignored outside IDLE.
REQ-013 SHALL compute MUL* by radix-2 shift-add over magnitudes for exactly 32 BUSY cycles, applying sign correction to the 64-bit product in the final cycle.
REQ-014 SHALL compute DIV* by restoring division over magnitudes for exactly 32 BUSY cycles; quotient sign = sign(a)^sign(b), remainder sign = sign(a) for signed ops.
REQ-015 SHALL raise out_valid exactly 33 cycles after the transfer edge for normal ops (32 BUSY plus 1 cycle into DONE).
REQ-016 SHALL on divide-by-zero go straight to DONE (out_valid next cycle): DIV/DIVU = 0xFFFFFFFF, REM/REMU = a.
REQ-017 SHALL on signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF) go straight to DONE: DIV = 0x80000000, REM = 0.
REQ-018 SHALL hold result, zero, illegal stable in DONE until out_ready; IDLE on the transfer edge.
REQ-019 SHALL not accept a new op in the same cycle as the output transfer; in_ready rises the following cycle.
REQ-020 SHALL on flush return to IDLE next edge from any state, drop out_valid, discard results; flush has priority over in_valid and out_ready.
REQ-021 SHALL drive zero = (result == 0) and qualify zero and illegal only while out_valid is high.

Reset
REQ-022 SHALL on rst enter IDLE: in_ready=1, out_valid=0, result=0, zero=0, illegal=0, iteration counter=0.
REQ-023 SHALL treat rst asserted mid-operation as flush with all outputs at reset values next edge; rst dominates flush.

Configuration
REQ-024 SHALL compile the divider only when MULDIV_DIV_EN is defined; with it defined, ops 100-111 behave per REQ-014..017.
REQ-025 SHALL without MULDIV_DIV_EN complete ops 100-111 one cycle after accept with result=0, illegal=1; MUL ops unchanged.

Structure
REQ-026 SHALL place the op encoding enum, XLEN and the iteration count (32) in shared package muldiv_pkg.
REQ-027 SHALL put the restoring divide iteration in sub-module div_iter (remainder/quotient step), excluded under !MULDIV_DIV_EN; FSM, multiplier and sign handling stay in muldiv_unit.

Verification
REQ-028 SHALL verify MUL a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, out_valid 33 cycles after accept.
REQ-029 SHALL verify MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000 with zero=1.
REQ-030 SHALL verify DIV a=-7, b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14.
REQ-031 SHALL verify DIVU a=5, b=0 -> 0xFFFFFFFF and REM a=0x80000000, b=-1 -> 0, out_valid one cycle after accept.
REQ-032 SHALL verify backpressure: out_ready low 5 cycles after out_valid keeps result stable; in_ready rises the cycle after the out transfer.
REQ-033 SHALL verify flush at BUSY cycle 10 -> IDLE next edge, out_valid never asserted, next op correct; build without MULDIV_DIV_EN: DIV -> result 0, illegal=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operand width,
// iteration count, funct3 op encoding and FSM state encoding.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    // RV32M funct3 encoding
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Divide-class ops all have funct3[2] set.
    function automatic logic op_is_div(input op_e o);
        return o[2];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One step of restoring division: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift the quotient bit in.
// Only built when MULDIV_DIV_EN is defined.
`ifdef MULDIV_DIV_EN
module div_iter #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // Trial subtraction; a borrow out of the top bit means restore.
    always_comb begin
        shifted = {rem_in, quo_in[W-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[W]) begin
            rem_out = shifted[W-1:0];
            quo_out = {quo_in[W-2:0], 1'b0};
        end else begin
            rem_out = diff[W-1:0];
            quo_out = {quo_in[W-2:0], 1'b1};
        end
    end

endmodule
`endif

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiply: 32-cycle radix-2 shift-add over operand magnitudes, sign fixed
// up on the last iteration. Divide (only with MULDIV_DIV_EN defined): 32-cycle
// restoring division via div_iter; divide-by-zero and signed overflow finish
// immediately. Without MULDIV_DIV_EN divide ops complete at once as illegal.
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high (in_valid/in_ready into the unit, out_valid/out_ready out of it);
// valid, once raised, is held with its payload stable until the transfer.
// in_ready is high only in IDLE, so a new op can never be taken in the same
// cycle as the output transfer. flush and rst abort everything on the next edge.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [1:0]      dbg_state
);

    import muldiv_pkg::*;

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    op_e                 op_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   mcand;
    logic [XLEN-1:0]     mplier;

    op_e                 op_in;
    logic                a_sgn_in;
    logic                b_sgn_in;
    logic                a_neg_in;
    logic                b_neg_in;
    logic                neg_in;
    logic [XLEN-1:0]     a_mag_in;
    logic [XLEN-1:0]     b_mag_in;

    logic [2*XLEN-1:0]   acc_sum;
    logic [2*XLEN-1:0]   prod_fin;
    logic [XLEN-1:0]     mul_res;
    logic [XLEN-1:0]     fin_res;

    assign op_in     = op_e'(op);
    assign dbg_state = state;

    // Which operands are treated as signed for each op.
    always_comb begin
        a_sgn_in = 1'b0;
        b_sgn_in = 1'b0;
        case (op_in)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_sgn_in = 1'b1;
                b_sgn_in = 1'b1;
            end
            OP_MULHSU: a_sgn_in = 1'b1;
            default: ;
        endcase
    end

    assign a_neg_in = a_sgn_in & a[XLEN-1];
    assign b_neg_in = b_sgn_in & b[XLEN-1];
    assign a_mag_in = a_neg_in ? (-a) : a;
    assign b_mag_in = b_neg_in ? (-b) : b;
    // Remainder takes the dividend's sign; product and quotient take the xor.
    assign neg_in   = (op_in == OP_REM || op_in == OP_REMU) ? a_neg_in
                                                            : (a_neg_in ^ b_neg_in);

    // Shift-add step and final sign correction / half selection.
    always_comb begin
        acc_sum  = acc + (mplier[0] ? mcand : '0);
        prod_fin = neg_q ? (-acc_sum) : acc_sum;
        mul_res  = (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] div_res;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    div_iter #(.W(XLEN)) u_div_iter (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // Early-out cases that bypass the iterative divider.
    always_comb begin
        div_zero    = (b == '0);
        div_ovf     = (op_in == OP_DIV || op_in == OP_REM) &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = op_in[1] ? a : '1;
        end else if (div_ovf) begin
            special_res = op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Final divide step with sign correction; funct3[1] selects remainder.
    always_comb begin
        if (op_q[1]) begin
            div_res = neg_q ? (-rem_nx) : rem_nx;
        end else begin
            div_res = neg_q ? (-quo_nx) : quo_nx;
        end
        fin_res = op_q[2] ? div_res : mul_res;
    end
`else
    assign fin_res = mul_res;
`endif

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // rst and flush share one abort path, so rst trivially dominates.
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q     <= op_in;
                        neg_q    <= neg_in;
                        acc      <= '0;
                        mcand    <= {{XLEN{1'b0}}, a_mag_in};
                        mplier   <= b_mag_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        if (op_is_div(op_in)) begin
`ifdef MULDIV_DIV_EN
                            rem_q  <= '0;
                            quo_q  <= a_mag_in;
                            dvsr_q <= b_mag_in;
                            if (div_zero || div_ovf) begin
                                state     <= ST_DONE;
                                out_valid <= 1'b1;
                                result    <= special_res;
                                zero      <= (special_res == '0);
                                illegal   <= 1'b0;
                            end else begin
                                state <= ST_BUSY;
                            end
`else
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= '0;
                            zero      <= 1'b1;
                            illegal   <= 1'b1;
`endif
                        end else begin
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
`ifdef MULDIV_DIV_EN
                    rem_q  <= rem_nx;
                    quo_q  <= quo_nx;
`endif
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= fin_res;
                        zero      <= (fin_res == '0);
                        illegal   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        zero      <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, expected responses
// queued at issue time and checked by an independent output monitor.
// Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

    localparam int W  = 32;
    localparam int EW = W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    op;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          illegal;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    vec_t mul_vecs[10];
    vec_t div_vecs[10];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .dbg_state (dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [EW-1:0] ex(input logic [W-1:0] r, input logic ill);
        return {ill, (r == '0), r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        @(posedge clk); #1;
        op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        // Scramble the inputs: the unit must have latched them already.
        in_valid = 1'b0;
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom_range(0, 7));
    endtask

    task automatic finish_op(input string name, input logic [EW-1:0] e, input int exp_lat, input int hold);
        int   lat;
        logic ok;
        exp_q.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || {illegal, zero, result} !== e) ok = 1'b0;
        end
        if (hold > 0) check({name, "_hold_stable"}, 64'(ok), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_no_ready_in_done"}, 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, "_ready_after_out"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_unexpected: got 0x%0h, expected no output", {illegal, zero, result});
            end else begin
                e = exp_q.pop_front();
                check("out_result", 64'({illegal, zero, result}), 64'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        a = '0; b = '0; op = 3'b000;

        mul_vecs[0] = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        mul_vecs[1] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        mul_vecs[2] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
        mul_vecs[3] = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
        mul_vecs[4] = '{3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 33};
        mul_vecs[5] = '{3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 33};
        mul_vecs[6] = '{3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        mul_vecs[7] = '{3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
        mul_vecs[8] = '{3'b001, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 33};
        mul_vecs[9] = '{3'b000, 32'd12345,    32'd1000,     32'd12345000, 33};

`ifdef MULDIV_DIV_EN
        div_vecs[0] = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        div_vecs[1] = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        div_vecs[2] = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
        div_vecs[3] = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
        div_vecs[4] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        div_vecs[5] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        div_vecs[6] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        div_vecs[7] = '{3'b111, 32'd5,        32'd0,        32'd5,        1};
        div_vecs[8] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        div_vecs[9] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
`else
        div_vecs[0] = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'd0, 1};
        div_vecs[1] = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'd0, 1};
        div_vecs[2] = '{3'b101, 32'd100,      32'd7,        32'd0, 1};
        div_vecs[3] = '{3'b111, 32'd100,      32'd7,        32'd0, 1};
        div_vecs[4] = '{3'b101, 32'd5,        32'd0,        32'd0, 1};
        div_vecs[5] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1};
        div_vecs[6] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1};
        div_vecs[7] = '{3'b111, 32'd5,        32'd0,        32'd0, 1};
        div_vecs[8] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'd0, 1};
        div_vecs[9] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd0, 1};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({in_ready, out_valid, result, zero, illegal, dbg_state}),
              64'({1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0}));
        @(posedge clk); #1;
        rst = 1'b0;

        // Multiply vectors
        foreach (mul_vecs[i]) begin
            start_op(mul_vecs[i].o, mul_vecs[i].x, mul_vecs[i].y);
            finish_op($sformatf("mul%0d", i), ex(mul_vecs[i].r, 1'b0), mul_vecs[i].lat, 0);
        end

        // Divide vectors (or illegal completions in the multiply-only build)
        foreach (div_vecs[i]) begin
            start_op(div_vecs[i].o, div_vecs[i].x, div_vecs[i].y);
`ifdef MULDIV_DIV_EN
            finish_op($sformatf("div%0d", i), ex(div_vecs[i].r, 1'b0), div_vecs[i].lat, 0);
`else
            finish_op($sformatf("div%0d", i), ex(div_vecs[i].r, 1'b1), div_vecs[i].lat, 0);
`endif
        end

        // Backpressure: out_ready held low 5 cycles after out_valid
        start_op(3'b000, 32'd3, 32'd5);
        finish_op("backpressure", ex(32'd15, 1'b0), 33, 5);

        // Flush in BUSY cycle 10
        start_op(3'b000, 32'd9, 32'd9);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_to_idle", 64'({dbg_state, in_ready, out_valid}), 64'({2'd0, 1'b1, 1'b0}));
        seen = 0;
        out_ready = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("flush_no_out_valid", 64'(seen), 64'd0);
        start_op(3'b000, 32'd6, 32'd7);
        finish_op("after_flush", ex(32'd42, 1'b0), 33, 0);

        // Reset in the middle of an operation
        start_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midop_reset", 64'({in_ready, out_valid, result, zero, illegal, dbg_state}),
              64'({1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0}));
        start_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("after_reset", ex(32'd1, 1'b0), 33, 0);

        repeat (5) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
